// File: rtl/pc_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
// The request is held with a stable address until the memory acknowledges it;
// the acknowledge may come in the same cycle as the request.
`timescale 1ns/1ps
interface pc_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter / instruction-fetch stage with a single registered
// IF/ID slot. Sequential next PC comes from an external pc+4 adder; redirects
// (taken branches/jumps) have priority and flush the slot. A redirect that
// arrives while a memory read is outstanding is parked until that read's ack,
// whose data is then thrown away.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   -> a redirect to a non-word-aligned target raises a sticky fault
//                and parks the fetch stage in HALT until reset.
//   undefined -> redirect targets are forced word-aligned, fault is tied low.
`timescale 1ns/1ps
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    pc_fetch_if.master  imem,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic        fault
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2,
        S_HALT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } state_t;
`endif

    state_t      state_reg;
    logic        pending_valid_reg;
    logic [31:0] pending_pc_reg;

    logic        req;
    logic        outstanding;
    logic        accept;
    logic        halted;
    logic [31:0] target;

    // Request whenever waiting for an instruction, or when the slot is being
    // drained this cycle so it can be refilled back-to-back.
    assign req         = (state_reg == S_REQ) || ((state_reg == S_FULL) && id_ready);
    assign imem.req    = req;
    assign imem.addr   = pc;

    // A request seen this cycle without its ack stays in flight past this edge.
    assign outstanding = req && !imem.ack;

    // Ack data is only kept if no redirect has been parked against it.
    assign accept      = req && imem.ack && !pending_valid_reg;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;

    assign target     = redirect_pc;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign halted     = (state_reg == S_HALT);

    // Sticky misaligned-redirect flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (!halted && redirect_valid && misaligned) begin
            fault <= 1'b1;
        end
    end
`else
    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign halted = 1'b0;
    assign fault  = 1'b0;
`endif

    // Fetch FSM: PC, pending redirect and the IF/ID slot all advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            pc                <= RESET_PC;
            if_valid          <= 1'b0;
            if_pc             <= 32'h0000_0000;
            if_instr          <= 32'h0000_0000;
            pending_valid_reg <= 1'b0;
            pending_pc_reg    <= 32'h0000_0000;
        end else if (halted) begin
            // Parked: no requests, redirects ignored, everything holds.
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (misaligned) begin
                pending_valid_reg <= 1'b0;
                state_reg         <= S_HALT;
            end else
`endif
            if (outstanding) begin
                // Address must stay stable until the ack, so park the target.
                pending_valid_reg <= 1'b1;
                pending_pc_reg    <= target;
                state_reg         <= S_REQ;
            end else begin
                // Nothing in flight (or its ack is this cycle and gets dropped).
                pending_valid_reg <= 1'b0;
                pc                <= target;
                state_reg         <= S_REQ;
            end
        end else if (accept) begin
            if_instr  <= imem.rdata;
            if_pc     <= pc;
            if_valid  <= 1'b1;
            pc        <= pc_plus4;
            state_reg <= S_FULL;
        end else begin
            case (state_reg)
                S_IDLE: state_reg <= S_REQ;
                S_REQ: begin
                    // An ack that was not accepted belongs to a flushed fetch.
                    if (imem.ack) begin
                        pc                <= pending_pc_reg;
                        pending_valid_reg <= 1'b0;
                    end
                end
                S_FULL: begin
                    // Slot consumed with no refill: wait for the next ack.
                    if (id_ready) begin
                        if_valid  <= 1'b0;
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch. A memory model with programmable ack
// latency answers the fetch port; expected fetch PCs are queued as stimulus is
// issued and popped when the IF/ID slot is consumed.
`timescale 1ns/1ps
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready = 1'b0;
    logic        fault;

    int          lat = 0;
    int          wait_cnt;
    logic        force_ack = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    pc_fetch_if imem();

    pc_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .fault          (fault)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always #5 clk = ~clk;

    assign pc_plus4   = pc + 32'd4;
    assign imem.ack   = force_ack || (imem.req && (wait_cnt >= lat));
    assign imem.rdata = instr_of(imem.addr);

    // Memory latency counter: cycles the current request has waited.
    always_ff @(posedge clk) begin
        if (!imem.req || imem.ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b0; force_ack = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lat = 0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (pc !== 32'h100) begin tests_failed++; $display("FAIL rst_pc: got %h want %h", pc, 32'h100); end
        tests_run++; if (imem.req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b want 0", imem.req); end
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        tests_run++; if (if_instr !== 32'h0) begin tests_failed++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL rst_fault: got %b want 0", fault); end
        rst = 1'b0;
        #1;
        tests_run++; if (imem.req !== 1'b0) begin tests_failed++; $display("FAIL idle_req: got %b want 0", imem.req); end
        step();
        tests_run++; if (imem.req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b want 1", imem.req); end
        tests_run++; if (imem.addr !== 32'h100) begin tests_failed++; $display("FAIL first_addr: got %h want %h", imem.addr, 32'h100); end
    endtask

    // Zero-wait memory, decode always ready: one instruction per cycle.
    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] e;
        id_ready = 1'b1;
        exp_pc = 32'h100;
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (imem.addr !== exp_pc || imem.req !== 1'b1) begin tests_failed++; $display("FAIL stream_addr: got req=%b addr=%h want req=1 addr=%h", imem.req, imem.addr, exp_pc); end
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            if (i > 0) begin
                tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid: got %b want 1", if_valid); end
                if (exp_q.size() > 1) begin
                    e = exp_q.pop_front();
                    $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
                    tests_run++; if (if_pc !== e || if_instr !== instr_of(e)) begin tests_failed++; $display("FAIL stream_slot: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, e, instr_of(e)); end
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset(); lat = 0;
        step();
        id_ready = 1'b1;
        exp_q.push_back(32'h100);
        step();
        exp_q.push_back(32'h104);
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_pc !== e) begin tests_failed++; $display("FAIL stall_pre: got %h want %h", if_pc, e); end
        step();
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (imem.req !== 1'b0) begin tests_failed++; $display("FAIL stall_req: got %b want 0", imem.req); end
            tests_run++; if (pc !== 32'h108 || if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== instr_of(32'h104)) begin tests_failed++; $display("FAIL stall_hold: got pc=%h v=%b if_pc=%h instr=%h want pc=108 v=1 if_pc=104 instr=%h", pc, if_valid, if_pc, if_instr, instr_of(32'h104)); end
            step();
        end
        id_ready = 1'b1;
        #1;
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h108) begin tests_failed++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=108", imem.req, imem.addr); end
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_pc !== e) begin tests_failed++; $display("FAIL stall_release: got %h want %h", if_pc, e); end
        exp_q.push_back(32'h108);
        step();
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_valid !== 1'b1 || if_pc !== e) begin tests_failed++; $display("FAIL stall_next: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, e); end
    endtask

    // Redirect while a 2-cycle-latency read is in flight.
    task automatic test_redirect_pending();
        logic [31:0] e;
        do_reset(); lat = 2; id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h10) begin tests_failed++; $display("FAIL pend_req0: got req=%b addr=%h want req=1 addr=10", imem.req, imem.addr); end
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        tests_run++; if (imem.addr !== 32'h10 || imem.ack !== 1'b0) begin tests_failed++; $display("FAIL pend_req1: got addr=%h ack=%b want addr=10 ack=0", imem.addr, imem.ack); end
        step();
        redirect_valid = 1'b0;
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h10 || imem.ack !== 1'b1) begin tests_failed++; $display("FAIL pend_hold: got req=%b addr=%h ack=%b want 1/10/1", imem.req, imem.addr, imem.ack); end
        step();
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL pend_discard: got if_valid=%b want 0", if_valid); end
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin tests_failed++; $display("FAIL pend_target: got req=%b addr=%h want req=1 addr=200", imem.req, imem.addr); end
        exp_q.push_back(32'h200);
        repeat (3) step();
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin tests_failed++; $display("FAIL pend_fill: got v=%b pc=%h instr=%h want v=1 pc=%h", if_valid, if_pc, if_instr, e); end
    endtask

    // Two redirects against one outstanding read: the later target wins.
    task automatic test_last_wins();
        do_reset(); lat = 3; id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h600;
        step();
        redirect_pc = 32'h700;
        step();
        redirect_valid = 1'b0;
        step();
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h700) begin tests_failed++; $display("FAIL last_wins: got req=%b addr=%h want req=1 addr=700", imem.req, imem.addr); end
    endtask

    // Redirect landing on the same edge as an ack.
    task automatic test_redirect_ack();
        logic [31:0] e;
        do_reset(); lat = 0; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_pc = 32'h400;
        #1;
        tests_run++; if (imem.ack !== 1'b1 || imem.addr !== 32'h20) begin tests_failed++; $display("FAIL rack_setup: got ack=%b addr=%h want ack=1 addr=20", imem.ack, imem.addr); end
        step();
        redirect_valid = 1'b0;
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rack_flush: got if_valid=%b want 0", if_valid); end
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h400) begin tests_failed++; $display("FAIL rack_target: got req=%b addr=%h want req=1 addr=400", imem.req, imem.addr); end
        exp_q.push_back(32'h400);
        step();
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_valid !== 1'b1 || if_pc !== e) begin tests_failed++; $display("FAIL rack_fill: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, e); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset(); lat = 0; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        tests_run++; if (imem.addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffffc", imem.addr); end
        exp_q.push_back(32'hFFFF_FFFC);
        step();
        tests_run++; if (imem.addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 00000000", imem.addr); end
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_pc !== e) begin tests_failed++; $display("FAIL wrap_slot0: got %h want %h", if_pc, e); end
        exp_q.push_back(32'h0);
        step();
        e = exp_q.pop_front();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_valid !== 1'b1 || if_pc !== e) begin tests_failed++; $display("FAIL wrap_slot1: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, e); end
    endtask

    task automatic test_align();
        do_reset(); lat = 0; id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h302;
        step();
        redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        tests_run++; if (fault !== 1'b1 || imem.req !== 1'b0) begin tests_failed++; $display("FAIL align_fault: got fault=%b req=%b want fault=1 req=0", fault, imem.req); end
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (fault !== 1'b1 || imem.req !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL align_halt: got fault=%b req=%b v=%b want 1/0/0", fault, imem.req, if_valid); end
            step();
        end
        do_reset();
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL align_clear: got fault=%b want 0", fault); end
`else
        tests_run++; if (fault !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h300) begin tests_failed++; $display("FAIL align_force: got fault=%b req=%b addr=%h want 0/1/300", fault, imem.req, imem.addr); end
        step();
        $display("[TB] fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin tests_failed++; $display("FAIL align_fill: got v=%b pc=%h want v=1 pc=300", if_valid, if_pc); end
`endif
    endtask

    // Reset in the middle of an outstanding read, with acks during reset.
    task automatic test_reset_midflight();
        do_reset(); lat = 3; id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h40) begin tests_failed++; $display("FAIL mid_req: got req=%b addr=%h want req=1 addr=40", imem.req, imem.addr); end
        rst = 1'b1;
        #1;
        tests_run++; if (pc !== 32'h100 || imem.req !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_async: got pc=%h req=%b v=%b want 100/0/0", pc, imem.req, if_valid); end
        force_ack = 1'b1;
        repeat (2) step();
        tests_run++; if (pc !== 32'h100 || if_valid !== 1'b0 || if_pc !== 32'h0) begin tests_failed++; $display("FAIL mid_ack_ignored: got pc=%h v=%b if_pc=%h want 100/0/0", pc, if_valid, if_pc); end
        force_ack = 1'b0; lat = 0;
        rst = 1'b0;
        #1;
        tests_run++; if (imem.req !== 1'b0) begin tests_failed++; $display("FAIL mid_idle: got req=%b want 0", imem.req); end
        step();
        tests_run++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin tests_failed++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=100", imem.req, imem.addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_last_wins();
        test_redirect_ack();
        test_wrap();
        test_align();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 pc  output  32  SHALL be the current fetch address; it feeds the external pc4 adder.
REQ-005 pc_plus4  input  32  SHALL be the pc4 adder result (pc + 4), used as the sequential next PC.
REQ-006 redirect_valid  input  1  SHALL mean a taken branch or jump for the current cycle.
REQ-007 redirect_pc  input  32  SHALL be the branch/jump target, sampled when redirect_valid=1.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  32  SHALL be the read address; it always equals pc.
REQ-010 imem_ack  input  1  SHALL mean imem_rdata is valid this cycle; it may arrive in the same cycle as imem_req.
REQ-011 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-012 if_valid, if_pc[31:0], if_instr[31:0]  outputs  SHALL form the registered IF/ID slot.
REQ-013 id_ready  input  1  SHALL mean the decode stage consumes the slot this cycle.
REQ-014 fault  output  1  SHALL be the misaligned-redirect flag (see Configuration).

Function
REQ-015 States SHALL be IDLE, REQ, FULL and HALT.
- IDLE->REQ unconditionally.
- REQ->FULL on an accepted ack.
- FULL->REQ when id_ready=1 and no ack.
REQ-016 imem_req SHALL be 1 in state REQ, 1 in state FULL when id_ready=1, and 0 otherwise.
REQ-017 Once imem_req is raised, imem_req and imem_addr SHALL stay constant until the imem_ack cycle.
REQ-018 On an accepted ack, the block SHALL perform the following on that edge:
- if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
- pc<=pc_plus4.
- The next state SHALL be FULL.
REQ-019 In FULL with id_ready=1, the slot SHALL be released and refilled in the same cycle if ack arrives, giving 1 instruction/cycle with a zero-wait memory.
REQ-020 In FULL with id_ready=0, all slot outputs and pc SHALL hold.
REQ-021 redirect_valid SHALL have priority over sequential advance.
- if_valid SHALL be cleared on the same edge (flush).
REQ-022 Redirect with no request outstanding: pc<=redirect_pc, and the next state SHALL be REQ.
REQ-023 Redirect while a request is outstanding and unacked: the target SHALL be held in a pending register and pc SHALL stay unchanged.
- The later ack data SHALL be discarded.
- Then pc<=pending target, and the next state SHALL be REQ.
REQ-024 Redirect in the same cycle as an ack: the ack data SHALL be discarded, pc<=redirect_pc, and the next state SHALL be REQ.
REQ-025 A second redirect while one is pending SHALL overwrite the pending target (last wins).
REQ-026 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC advances to 32'h0000_0000 when pc_plus4 wraps).

Reset
REQ-027 Asserting rst SHALL immediately force the following:
- pc=RESET_PC, state=IDLE.
- if_valid=0, if_pc=0, if_instr=0.
- The pending redirect SHALL be cleared, fault=0, imem_req=0.
REQ-028 A request outstanding when rst asserts SHALL be abandoned, and any ack arriving during reset SHALL be ignored.
REQ-029 The first imem_req SHALL occur one cycle after rst deasserts (IDLE->REQ).

Configuration
REQ-030 With macro PC_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL cause the following:
- fault<=1, sticky until reset.
- if_valid<=0.
- Entry to HALT, which SHALL issue no requests and accept no redirects.
REQ-031 Without PC_ALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 2'b00, fault SHALL be tied 0, and HALT SHALL not exist.

Verification
REQ-032 Release rst with RESET_PC=32'h100 and a zero-wait memory (ack=req) -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles and if_valid=1 continuously.
REQ-033 Hold id_ready=0 for 3 cycles with if_pc=0x104 -> imem_req=0, and pc and if_* stay stable; release -> fetch resumes at 0x108.
REQ-034 Memory with 2-cycle ack latency, redirect to 0x200 in the cycle after req@0x10 -> imem_addr holds 0x10 until ack, that data is discarded, and the next req goes to 0x200.
REQ-035 Redirect to 0x400 coincident with ack of 0x20 -> if_valid=0 next cycle, and the next fetched if_pc=0x400.
REQ-036 pc=0xFFFF_FFFC fetched -> the next imem_addr is 0x0000_0000.
REQ-037 With PC_ALIGN_CHECK_EN defined, redirect to 0x302 -> fault=1, imem_req stays 0 until rst; without the macro -> the fetch goes to 0x300 and fault=0.
